mac_column_sequencer: RTL and testbench
=======================================

Name: mac_column_sequencer

Overview:
- Controller that drives one 16-lane, 2-group bit-column MAC unit through a full 8-bit weight tile.
- Accepts per-column configuration descriptors over a valid/ready stream and latches per-tile group sums.
- Primes the MAC's internal pipeline registers, steps `column_idx` LSB->MSB, flushes the last column and signals result-valid.
- Sits between the weight-preprocessing/descriptor FIFO and the MAC datapath.

Parameters:
- DATA_WIDTH, 8, activation width.
- VEC_LENGTH, 16, activation lanes per MAC.
- NUM_COLS, 8, weight bit columns per tile; must be <= 8.
- MUX_SEL_WIDTH, $clog2(VEC_LENGTH)+1, select width of the hamming mux.
- SUM_ACT_WIDTH, $clog2(VEC_LENGTH)+DATA_WIDTH, group-sum width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- tile_sum_act  in  2x(SUM_ACT_WIDTH-1)  per-group activation sums; latched on accepted start
- busy  out  1  high in every state except IDLE
- cfg_valid  in  1  column descriptor valid
- cfg_ready  out  1  high only in RUN
- cfg_act_sel  in  (VEC_LENGTH/2)x(MUX_SEL_WIDTH-1)  packed lane selects
- cfg_hamming_sel  in  MUX_SEL_WIDTH  hamming lane select
- cfg_hamming_sign  in  1  negate hamming activation
- cfg_mul_const  in  3  constant multiplier
- cfg_is_shift_mul  in  1  shift constant product by 3
- cfg_skip_zero  in  2  per-group skip-bit-0 flags
- mac_en, mac_clear  out  1 each  to MAC en / reset
- mac_act_sel, mac_hamming_sel, mac_hamming_sign, mac_mul_const, mac_is_shift_mul, mac_skip_zero  out  same widths as cfg_*  registered MAC controls
- mac_sum_act  out  2x(SUM_ACT_WIDTH-1)  latched tile sums
- mac_column_idx  out  3  current column
- mac_is_msb  out  1  current column is NUM_COLS-1
- result_valid  out  1  one-cycle pulse: MAC result holds the tile sum

Behaviour:
- Reset: state=IDLE, col_cnt=0, all outputs 0, except:
  - mac_clear=1;
  - the zero-config outputs: mac_act_sel lanes all = 8 (zero input of the 9:1 mux), mac_hamming_sel = VEC_LENGTH (zero input of the 17:1 mux), mac_skip_zero = 2'b11.
  - All other MAC controls are 0.
- The zero config guarantees a zero contribution to both MAC pipeline registers.
- IDLE:
  - mac_en=0, mac_clear=0.
  - start=1 latches tile_sum_act into mac_sum_act and goes to ZERO.
- ZERO (1 cycle): mac_en=1 with zero config; flushes stale MAC pipeline registers. -> CLEAR.
- CLEAR (1 cycle): mac_clear=1, mac_en=0; MAC result <= 0. -> RUN, col_cnt=0.
- RUN:
  - cfg_ready=1.
  - On handshake (cfg_valid&cfg_ready), in the same cycle:
    - mac_en=1;
    - mac_* = cfg_* (combinational pass from descriptor, registered at MAC);
    - mac_column_idx = col_cnt;
    - mac_is_msb = (col_cnt == NUM_COLS-1).
  - After each handshake, col_cnt++.
  - On the handshake with col_cnt == NUM_COLS-1: col_cnt <= 0 and go to DRAIN.
  - No cfg_valid (bubble): mac_en=0, controls revert to zero config, col_cnt holds; the MAC state is frozen.
- DRAIN (1 cycle): mac_en=1, zero config; the MAC adds the last column. -> DONE.
- DONE (1 cycle): result_valid=1, mac_en=0. -> IDLE.
- Latency: with no bubbles, start to result_valid = NUM_COLS+4 cycles. start at cycle 0 gives result_valid at cycle NUM_COLS+4.
- start in any non-IDLE state is ignored. busy falls in the cycle after DONE.
- reset in any state returns to IDLE next edge:
  - mac_clear=1 during reset;
  - no result_valid;
  - the partially consumed tile is abandoned; the upstream FIFO must be flushed by its owner.
- start and reset together: reset wins.
- cfg_* outside RUN: cfg_ready=0 and nothing is consumed.
- mac_sum_act stays constant from the start accept until the next accepted start.

Test Plan:
1. reset 2 cycles, then idle 3 cycles -> busy=0, mac_en=0, mac_clear=0 after reset, result_valid never high, zero-config selects (act_sel=8, hamming_sel=16, skip_zero=11).
2. start with tile_sum_act={100,-50}, 8 back-to-back descriptors -> ZERO, CLEAR, 8 RUN cycles with column_idx 0..7; is_msb only on idx 7; DRAIN; result_valid at cycle 12; MAC result matches golden bit-serial dot product.
3. As scenario 2 with cfg_valid low for 3 cycles after column 2 -> mac_en=0 and column_idx held during the bubble; result_valid at cycle 15; same result.
4. start pulsed during RUN, and start=1 held continuously -> the in-flight tile is unaffected; a new tile begins only from IDLE, so the second ZERO starts the cycle after DONE+1.
5. reset asserted during RUN at column 4 -> IDLE next cycle, no result_valid, cfg_ready=0; a following clean tile produces the correct result, proving no stale partial sum.
6. Two tiles back-to-back with different tile_sum_act -> the second result excludes the first tile's contribution; mac_sum_act switches only at the second start accept.

Source files
------------

// File: rtl/mac_column_sequencer.sv
// Sequences a bit-column MAC through one weight tile: zero-flush, clear, NUM_COLS columns, drain, result pulse.
// Latency: start to result_valid is NUM_COLS+4 cycles plus bubbles; descriptors are backpressured via cfg_ready (RUN only).
module mac_column_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int NUM_COLS      = 8,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [2*(SUM_ACT_WIDTH-1)-1:0]                tile_sum_act,
    output logic                                          busy,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]   cfg_act_sel,
    input  logic [MUX_SEL_WIDTH-1:0]                      cfg_hamming_sel,
    input  logic                                          cfg_hamming_sign,
    input  logic [2:0]                                    cfg_mul_const,
    input  logic                                          cfg_is_shift_mul,
    input  logic [1:0]                                    cfg_skip_zero,
    output logic                                          mac_en,
    output logic                                          mac_clear,
    output logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]   mac_act_sel,
    output logic [MUX_SEL_WIDTH-1:0]                      mac_hamming_sel,
    output logic                                          mac_hamming_sign,
    output logic [2:0]                                    mac_mul_const,
    output logic                                          mac_is_shift_mul,
    output logic [1:0]                                    mac_skip_zero,
    output logic [2*(SUM_ACT_WIDTH-1)-1:0]                mac_sum_act,
    output logic [2:0]                                    mac_column_idx,
    output logic                                          mac_is_msb,
    output logic                                          result_valid
);

    localparam int LANE_W = MUX_SEL_WIDTH - 1;
    localparam int LANES  = VEC_LENGTH / 2;
    localparam logic [LANE_W-1:0]          LANE_ZERO    = LANE_W'(VEC_LENGTH / 2);
    localparam logic [LANES*LANE_W-1:0]    ACT_SEL_ZERO = {LANES{LANE_ZERO}};
    localparam logic [MUX_SEL_WIDTH-1:0]   HAM_SEL_ZERO = MUX_SEL_WIDTH'(VEC_LENGTH);
    localparam logic [2:0]                 LAST_COL     = 3'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                          state, state_nxt;
    logic [2:0]                      col_cnt, col_cnt_nxt;
    logic [2*(SUM_ACT_WIDTH-1)-1:0]  sum_act_q;
    logic                            sum_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            col_cnt   <= 3'd0;
            sum_act_q <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_cnt_nxt;
            if (sum_load) begin
                sum_act_q <= tile_sum_act;
            end
        end
    end

    assign mac_sum_act = sum_act_q;

    always_comb begin
        state_nxt        = state;
        col_cnt_nxt      = col_cnt;
        sum_load         = 1'b0;
        busy             = 1'b0;
        cfg_ready        = 1'b0;
        mac_en           = 1'b0;
        mac_clear        = 1'b0;
        result_valid     = 1'b0;
        // zero config: every mux parked on its zero input, both groups skipped
        mac_act_sel      = ACT_SEL_ZERO;
        mac_hamming_sel  = HAM_SEL_ZERO;
        mac_hamming_sign = 1'b0;
        mac_mul_const    = 3'd0;
        mac_is_shift_mul = 1'b0;
        mac_skip_zero    = 2'b11;
        mac_column_idx   = 3'd0;
        mac_is_msb       = 1'b0;

        if (reset) begin
            mac_clear = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sum_load  = 1'b1;
                        state_nxt = S_ZERO;
                    end
                end
                S_ZERO: begin
                    busy      = 1'b1;
                    mac_en    = 1'b1;
                    state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    busy        = 1'b1;
                    mac_clear   = 1'b1;
                    col_cnt_nxt = 3'd0;
                    state_nxt   = S_RUN;
                end
                S_RUN: begin
                    busy           = 1'b1;
                    cfg_ready      = 1'b1;
                    mac_column_idx = col_cnt;
                    if (cfg_valid) begin
                        mac_en           = 1'b1;
                        mac_act_sel      = cfg_act_sel;
                        mac_hamming_sel  = cfg_hamming_sel;
                        mac_hamming_sign = cfg_hamming_sign;
                        mac_mul_const    = cfg_mul_const;
                        mac_is_shift_mul = cfg_is_shift_mul;
                        mac_skip_zero    = cfg_skip_zero;
                        mac_is_msb       = (col_cnt == LAST_COL);
                        if (col_cnt == LAST_COL) begin
                            col_cnt_nxt = 3'd0;
                            state_nxt   = S_DRAIN;
                        end else begin
                            col_cnt_nxt = col_cnt + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    busy      = 1'b1;
                    mac_en    = 1'b1;
                    state_nxt = S_DONE;
                end
                S_DONE: begin
                    busy         = 1'b1;
                    result_valid = 1'b1;
                    state_nxt    = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_column_sequencer.sv
// Bench for mac_column_sequencer: directed tiles, a toy pipelined MAC model and a queue-based scoreboard.
module tb_mac_column_sequencer;

    localparam int NUM_COLS = 8;

    logic        clk = 1'b0;
    logic        reset, start, cfg_valid;
    logic [21:0] tile_sum_act;
    logic [31:0] cfg_act_sel;
    logic [4:0]  cfg_hamming_sel;
    logic        cfg_hamming_sign, cfg_is_shift_mul;
    logic [2:0]  cfg_mul_const;
    logic [1:0]  cfg_skip_zero;

    logic        busy, cfg_ready, mac_en, mac_clear, mac_hamming_sign, mac_is_shift_mul;
    logic        mac_is_msb, result_valid;
    logic [31:0] mac_act_sel;
    logic [4:0]  mac_hamming_sel;
    logic [2:0]  mac_mul_const, mac_column_idx;
    logic [1:0]  mac_skip_zero;
    logic [21:0] mac_sum_act;

    mac_column_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .tile_sum_act(tile_sum_act), .busy(busy),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_act_sel(cfg_act_sel),
        .cfg_hamming_sel(cfg_hamming_sel), .cfg_hamming_sign(cfg_hamming_sign),
        .cfg_mul_const(cfg_mul_const), .cfg_is_shift_mul(cfg_is_shift_mul),
        .cfg_skip_zero(cfg_skip_zero), .mac_en(mac_en), .mac_clear(mac_clear),
        .mac_act_sel(mac_act_sel), .mac_hamming_sel(mac_hamming_sel),
        .mac_hamming_sign(mac_hamming_sign), .mac_mul_const(mac_mul_const),
        .mac_is_shift_mul(mac_is_shift_mul), .mac_skip_zero(mac_skip_zero),
        .mac_sum_act(mac_sum_act), .mac_column_idx(mac_column_idx),
        .mac_is_msb(mac_is_msb), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic        msb;
        logic [4:0]  hs;
        logic [31:0] act;
        logic [1:0]  skip;
    } col_t;

    typedef struct {
        int          val;
        logic [21:0] sums;
        int          start;
        int          lat;
    } res_t;

    col_t        col_q[$];
    res_t        res_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_done = -100;
    logic [2:0]  hold_idx = 3'd0;
    logic [21:0] prev_sums = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, $signed(act), act, $signed(exp), exp, cyc);
        end
    endtask

    // Toy MAC: one control-register stage feeding an accumulator; zero config contributes nothing.
    function automatic int col_term(input logic [31:0] act, input logic [4:0] hs, input logic sg,
                                    input logic [2:0] mc, input logic sh, input logic [2:0] idx,
                                    input logic msb);
        int v, t;
        v = (hs >= 5'd16) ? 0 : int'(hs) + 1;
        t = (sg ? -v : v) + ((act[3:0] == 4'd8) ? 0 : int'(act[3:0])) + int'(mc) * (sh ? 8 : 1);
        t = t * (1 << idx);
        return msb ? -t : t;
    endfunction

    int m_stage = 0;
    int m_res = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_en)
            m_stage <= col_term(mac_act_sel, mac_hamming_sel, mac_hamming_sign, mac_mul_const,
                                mac_is_shift_mul, mac_column_idx, mac_is_msb);
        if (mac_clear)   m_res <= 0;
        else if (mac_en) m_res <= m_res + m_stage;
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or a result.
    always @(negedge clk) begin
        col_t e;
        res_t r;
        if (cfg_ready && cfg_valid) begin
            if (col_q.size() == 0) begin
                chk("unexpected_handshake", 1, 0);
            end else begin
                e = col_q.pop_front();
                chk("hs_mac_en", mac_en, 1);
                chk("hs_column_idx", mac_column_idx, e.idx);
                chk("hs_is_msb", mac_is_msb, e.msb);
                chk("hs_hamming_sel", mac_hamming_sel, e.hs);
                chk("hs_act_sel", mac_act_sel, e.act);
                chk("hs_skip_zero", mac_skip_zero, e.skip);
                hold_idx = e.idx + 3'd1;
            end
        end else if (cfg_ready) begin
            chk("bubble_mac_en", mac_en, 0);
            chk("bubble_hamming_sel", mac_hamming_sel, 16);
            chk("bubble_column_idx", mac_column_idx, hold_idx);
        end
        if (result_valid) begin
            if (res_q.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                r = res_q.pop_front();
                chk("tile_result", m_res, r.val);
                chk("tile_latency", cyc - r.start, r.lat);
                chk("tile_sum_act", mac_sum_act, r.sums);
                last_done = cyc;
            end
        end
    end

    task automatic set_cfg(input int set, input int i);
        if (set == 0) begin
            cfg_act_sel = 32'h8888_8888; cfg_hamming_sel = 5'(i); cfg_hamming_sign = 1'b0;
            cfg_mul_const = 3'd0; cfg_is_shift_mul = 1'b0; cfg_skip_zero = 2'b10;
        end else begin
            cfg_act_sel = 32'h8888_8885; cfg_hamming_sel = 5'd2; cfg_hamming_sign = 1'b1;
            cfg_mul_const = 3'd3; cfg_is_shift_mul = 1'b1; cfg_skip_zero = 2'b01;
        end
    endtask

    task automatic do_tile(input int set, input int bub_col, input int bub_len, input int abort_col,
                           input logic [21:0] sums, input int exp_val, input bit hold,
                           input bit chained);
        int   n;
        res_t r;
        col_t e;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("idle_wait_timeout", n < 100, 1);
        chk("sum_act_before_start", mac_sum_act, prev_sums);
        if (chained) chk("restart_cycle", cyc, last_done + 1);
        start = 1'b1;
        tile_sum_act = sums;
        r.val = exp_val; r.sums = sums; r.start = cyc; r.lat = NUM_COLS + 4 + bub_len;
        res_q.push_back(r);
        prev_sums = sums;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        tile_sum_act = ~sums;
        for (int i = 0; i < NUM_COLS; i++) begin
            set_cfg(set, i);
            cfg_valid = 1'b1;
            if (i == abort_col) begin
                reset = 1'b1;
                #1;
                chk("abort_mac_clear", mac_clear, 1);
                chk("abort_mac_en", mac_en, 0);
                chk("abort_cfg_ready", cfg_ready, 0);
                r = res_q.pop_back();
                prev_sums = '0;
                @(posedge clk); #1;
                reset = 1'b0;
                cfg_valid = 1'b0;
                @(negedge clk);
                chk("post_abort_busy", busy, 0);
                chk("post_abort_cfg_ready", cfg_ready, 0);
                chk("post_abort_mac_clear", mac_clear, 0);
                return;
            end
            e.idx = 3'(i); e.msb = (i == NUM_COLS - 1); e.hs = cfg_hamming_sel;
            e.act = cfg_act_sel; e.skip = cfg_skip_zero;
            col_q.push_back(e);
            n = 0;
            @(negedge clk);
            while (cfg_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("ready_wait_timeout", n < 50, 1);
            @(posedge clk); #1;
            if (i == bub_col) begin
                cfg_valid = 1'b0;
                repeat (bub_len) @(posedge clk);
                #1;
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; tile_sum_act = '0;
        set_cfg(0, 0);
        @(negedge clk);
        chk("reset_mac_clear", mac_clear, 1);
        chk("reset_mac_en", mac_en, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_mac_en", mac_en, 0);
            chk("idle_mac_clear", mac_clear, 0);
            chk("idle_cfg_ready", cfg_ready, 0);
            chk("idle_act_sel", mac_act_sel, 32'h8888_8888);
            chk("idle_hamming_sel", mac_hamming_sel, 16);
            chk("idle_skip_zero", mac_skip_zero, 2'b11);
            chk("idle_mul_const", mac_mul_const, 0);
            chk("idle_sum_act", mac_sum_act, 0);
        end

        // column-weighted terms 1..8: 769 - 1024
        do_tile(0, -1, 0, -1, {11'd100, 11'h7CE}, -255, 1'b0, 1'b0);
        do_tile(0, 2, 3, -1, {11'd100, 11'h7CE}, -255, 1'b0, 1'b0);
        // constant term 26 per column: 26*127 - 26*128
        do_tile(1, -1, 0, -1, 22'h0A_5A5, -26, 1'b1, 1'b0);
        do_tile(0, -1, 0, -1, 22'h15_A5A, -255, 1'b0, 1'b1);
        do_tile(0, -1, 0, 4, 22'h00_123, 0, 1'b0, 1'b0);
        do_tile(1, -1, 0, -1, 22'h3F_00F, -26, 1'b0, 1'b0);
        do_tile(1, -1, 0, -1, 22'h01_111, -26, 1'b0, 1'b0);
        do_tile(0, -1, 0, -1, 22'h02_222, -255, 1'b0, 1'b0);

        n = 0;
        while (res_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("final_result_timeout", n < 50, 1);
        repeat (3) @(negedge clk);
        chk("final_busy", busy, 0);
        chk("final_col_q_empty", col_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
